// File: rtl/neuron_mac_seq.sv
// Sequential MAC neuron: streams N_IN weight/input beats, adds bias, applies ReLU.
// Optional output saturation with overflow flag under macro NEURON_SAT_EN.
module neuron_mac_seq #(
  parameter int N_IN = 10,
  parameter int DW   = 16,
  parameter int AW   = 40,
  parameter int OW   = 32,
  parameter int FRAC = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic signed [DW-1:0] bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_w,
  input  logic signed [DW-1:0] in_x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_data,
  output logic                 busy,
  output logic                 ovf
);

  if (N_IN < 1) begin : g_bad_n_in
    $error("neuron_mac_seq: N_IN must be at least 1");
  end
  if (AW < 2*DW + $clog2(N_IN) + 1) begin : g_bad_aw
    $error("neuron_mac_seq: AW too narrow for N_IN products of width 2*DW");
  end
  if (OW > AW) begin : g_bad_ow
    $error("neuron_mac_seq: OW must not exceed AW");
  end

  localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_IN - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_OUT} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic signed [DW-1:0]   bias_q;
  logic signed [2*DW-1:0] prod;
  logic                   prod_vld;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW-1:0]   bias_ext;
  logic signed [AW-1:0]   sum;
  logic signed [AW-1:0]   r;
  logic signed [OW-1:0]   fit;
  logic                   beat;

  assign beat     = in_valid & in_ready;
  assign prod_ext = AW'(prod);
  assign bias_ext = AW'(bias_q) <<< FRAC;

  // The last product is still in the product stage during DRAIN, so it is
  // folded in here instead of spending an extra cycle on the accumulator.
  always_comb begin
    sum = acc + (prod_vld ? prod_ext : '0) + bias_ext;
    r   = sum >>> FRAC;
  end

`ifdef NEURON_SAT_EN
  localparam logic signed [AW-1:0] OMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  logic fit_ovf;

  always_comb begin
    fit     = r[OW-1:0];
    fit_ovf = 1'b0;
    if (r[AW-1]) begin
      fit = '0;
    end else if (r > OMAX) begin
      fit     = OMAX[OW-1:0];
      fit_ovf = 1'b1;
    end
  end
`else
  logic unused_r;

  always_comb fit = r[AW-1] ? '0 : r[OW-1:0];
  assign unused_r = ^r;
  assign ovf      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      prod      <= '0;
      prod_vld  <= 1'b0;
      bias_q    <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef NEURON_SAT_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            bias_q   <= bias;
            acc      <= '0;
            cnt      <= '0;
            prod_vld <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= S_ACC;
          end
        end
        S_ACC: begin
          prod_vld <= beat;
          if (beat) begin
            prod <= in_w * in_x;
          end
          if (prod_vld) begin
            acc <= acc + prod_ext;
          end
          if (beat) begin
            if (cnt == LAST) begin
              in_ready <= 1'b0;
              state    <= S_DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          out_data  <= fit;
`ifdef NEURON_SAT_EN
          ovf       <= fit_ovf;
`endif
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq: three instances (N_IN=4, N_IN=2/OW=16, N_IN=1/FRAC=2),
// a vector table plus random ops and reset corner sequences; follows NEURON_SAT_EN.
module tb_neuron_mac_seq;

  typedef struct {
    int      k;
    int      n;
    shortint w[4];
    shortint x[4];
    shortint bias;
    int      gap;
    int      hold;
  } vec_t;

  typedef struct {
    longint data;
    bit     ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic [2:0]        start, in_valid, out_ready;
  logic [2:0]        in_ready, out_valid, busy, ovf;
  logic signed [15:0] bias_s [3];
  logic signed [15:0] in_w [3];
  logic signed [15:0] in_x [3];
  logic signed [31:0] od_a, od_c;
  logic signed [15:0] od_b;

  int checks = 0;
  int failures = 0;

  exp_t sb0[$], sb1[$], sb2[$];
  vec_t vecs[10];

  neuron_mac_seq #(.N_IN(4), .DW(16), .AW(40), .OW(32), .FRAC(0)) u_a (
    .clk(clk), .rstn(rstn), .start(start[0]), .bias(bias_s[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_w(in_w[0]), .in_x(in_x[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od_a),
    .busy(busy[0]), .ovf(ovf[0]));

  neuron_mac_seq #(.N_IN(2), .DW(16), .AW(40), .OW(16), .FRAC(0)) u_b (
    .clk(clk), .rstn(rstn), .start(start[1]), .bias(bias_s[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_w(in_w[1]), .in_x(in_x[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(od_b),
    .busy(busy[1]), .ovf(ovf[1]));

  neuron_mac_seq #(.N_IN(1), .DW(16), .AW(40), .OW(32), .FRAC(2)) u_c (
    .clk(clk), .rstn(rstn), .start(start[2]), .bias(bias_s[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_w(in_w[2]), .in_x(in_x[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(od_c),
    .busy(busy[2]), .ovf(ovf[2]));

  function automatic longint od(int k);
    case (k)
      0:       return longint'(od_a);
      1:       return longint'(od_b);
      default: return longint'(od_c);
    endcase
  endfunction

  // Reference: exact dot product + aligned bias, shift, ReLU, then fit to OW.
  function automatic exp_t model(vec_t v);
    exp_t   e;
    longint s;
    longint maxv;
    int     frac;
    int     ow;
    frac = (v.k == 2) ? 2 : 0;
    ow   = (v.k == 1) ? 16 : 32;
    maxv = (64'sd1 <<< (ow - 1)) - 1;
    s    = 0;
    for (int i = 0; i < v.n; i++) s += longint'(v.w[i]) * longint'(v.x[i]);
    s += longint'(v.bias) <<< frac;
    s = s >>> frac;
    if (s < 0) s = 0;
`ifdef NEURON_SAT_EN
    if (s > maxv) begin
      e.data = maxv;
      e.ovf  = 1'b1;
    end else begin
      e.data = s;
      e.ovf  = 1'b0;
    end
`else
    e.data = (s <<< (64 - ow)) >>> (64 - ow);
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(int k, exp_t e);
    case (k)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endfunction

  // Scoreboard side: every handshake must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    int   sz;
    for (int k = 0; k < 3; k++) begin
      if (rstn === 1'b1 && out_valid[k] && out_ready[k]) begin
        case (k)
          0:       sz = sb0.size();
          1:       sz = sb1.size();
          default: sz = sb2.size();
        endcase
        chk($sformatf("sb_pending%0d", k), longint'(sz > 0), 1);
        if (sz > 0) begin
          case (k)
            0:       e = sb0.pop_front();
            1:       e = sb1.pop_front();
            default: e = sb2.pop_front();
          endcase
          chk($sformatf("out_data%0d", k), od(k), e.data);
          chk($sformatf("ovf%0d", k), longint'(ovf[k]), longint'(e.ovf));
        end
      end
    end
  end

  // All tasks begin and end 1ns after a rising edge.
  task automatic start_op(int k, shortint b);
    start[k] = 1'b1; bias_s[k] = b;
    in_valid[k] = 1'b1; in_w[k] = 16'sd100; in_x[k] = 16'sd100;
    @(negedge clk);
    chk("idle_in_ready", longint'(in_ready[k]), 0);
    chk("idle_busy", longint'(busy[k]), 0);
    @(posedge clk); #1;
    start[k] = 1'b0; in_valid[k] = 1'b0; bias_s[k] = 16'sh7fff;
  endtask

  task automatic beat(int k, shortint w, shortint x);
    in_w[k] = w; in_x[k] = x; in_valid[k] = 1'b1;
    @(negedge clk);
    chk("acc_in_ready", longint'(in_ready[k]), 1);
    chk("acc_busy", longint'(busy[k]), 1);
    @(posedge clk); #1;
    in_valid[k] = 1'b0; in_w[k] = -16'sd1; in_x[k] = -16'sd1;
  endtask

  task automatic finish_op(int k, exp_t e, int hold);
    in_valid[k] = 1'b1; in_w[k] = 16'sd7; in_x[k] = 16'sd7;
    @(negedge clk);
    chk("drain_in_ready", longint'(in_ready[k]), 0);
    chk("drain_out_valid", longint'(out_valid[k]), 0);
    @(posedge clk); #1;
    in_valid[k] = 1'b0; start[k] = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_out_valid", longint'(out_valid[k]), 1);
      chk("hold_out_data", od(k), e.data);
      chk("hold_busy", longint'(busy[k]), 1);
      @(posedge clk); #1;
    end
    out_ready[k] = 1'b1;
    @(negedge clk);
    chk("latency_out_valid", longint'(out_valid[k]), 1);
    @(posedge clk); #1;
    out_ready[k] = 1'b0; start[k] = 1'b0;
    @(negedge clk);
    chk("post_out_valid", longint'(out_valid[k]), 0);
    chk("post_busy", longint'(busy[k]), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_op(vec_t v);
    exp_t e;
    e = model(v);
    push(v.k, e);
    start_op(v.k, v.bias);
    for (int i = 0; i < v.n; i++) begin
      repeat (v.gap) begin
        @(posedge clk); #1;
      end
      beat(v.k, v.w[i], v.x[i]);
    end
    finish_op(v.k, e, v.hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    exp_t e;

    vecs[0] = '{0, 4, '{1, 2, 3, 4}, '{5, 6, 7, 8}, 10, 0, 0};
    vecs[1] = '{0, 4, '{-3, -3, -3, -3}, '{2, 2, 2, 2}, 5, 0, 0};
    vecs[2] = '{0, 4, '{1, 2, 3, 4}, '{5, 6, 7, 8}, 10, 3, 5};
    vecs[3] = '{0, 4, '{-100, 200, -300, 400}, '{7, 8, -9, 10}, -20, 1, 1};
    vecs[4] = '{0, 4, '{32767, -32768, 32767, -32768}, '{32767, -32768, 32767, -32768}, 32767, 0, 2};
    vecs[5] = '{1, 2, '{32767, 32767, 0, 0}, '{2, 2, 0, 0}, 0, 0, 0};
    vecs[6] = '{1, 2, '{100, -3, 0, 0}, '{5, 7, 0, 0}, -1, 2, 1};
    vecs[7] = '{2, 1, '{10, 0, 0, 0}, '{-3, 0, 0, 0}, 9, 0, 0};
    vecs[8] = '{2, 1, '{-7, 0, 0, 0}, '{5, 0, 0, 0}, 2, 1, 2};
    vecs[9] = '{2, 1, '{1000, 0, 0, 0}, '{1001, 0, 0, 0}, 0, 0, 0};

    rstn = 1'b0;
    start = '0; in_valid = '0; out_ready = '0;
    for (int k = 0; k < 3; k++) begin
      bias_s[k] = '0; in_w[k] = '0; in_x[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", longint'(out_valid[k]), 0);
      chk("rst_in_ready", longint'(in_ready[k]), 0);
      chk("rst_busy", longint'(busy[k]), 0);
      chk("rst_ovf", longint'(ovf[k]), 0);
      chk("rst_out_data", od(k), 0);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    for (int i = 0; i < 6; i++) begin
      rv.k = 0; rv.n = 4;
      for (int j = 0; j < 4; j++) begin
        rv.w[j] = shortint'($urandom_range(0, 65535));
        rv.x[j] = shortint'($urandom_range(0, 65535));
      end
      rv.bias = shortint'($urandom_range(0, 65535));
      rv.gap  = int'($urandom_range(0, 2));
      rv.hold = int'($urandom_range(0, 3));
      run_op(rv);
    end

    // Reset in the middle of accumulation: nothing may come out afterwards.
    start_op(0, 10);
    beat(0, 1, 5);
    beat(0, 2, 6);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("midacc_rst_in_ready", longint'(in_ready[0]), 0);
    chk("midacc_rst_busy", longint'(busy[0]), 0);
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_stale_out_valid", longint'(out_valid[0]), 0);
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b0;
    run_op(vecs[0]);

    // Reset while the result is waiting in OUT.
    e = model(vecs[0]);
    start_op(0, 10);
    for (int i = 0; i < 4; i++) beat(0, vecs[0].w[i], vecs[0].x[i]);
    @(posedge clk); #1;
    @(negedge clk);
    chk("out_before_rst_valid", longint'(out_valid[0]), 1);
    chk("out_before_rst_data", od(0), e.data);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("out_rst_valid", longint'(out_valid[0]), 0);
    chk("out_rst_data", od(0), 0);
    chk("out_rst_busy", longint'(busy[0]), 0);
    @(posedge clk); #1;
    run_op(vecs[3]);

    repeat (3) @(posedge clk);
    chk("sb_drained", longint'(sb0.size() + sb1.size() + sb2.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
